// File: rtl/he_xpose_pkg.sv
// Shared definitions for the switch-stage transpose network: chunk sizing and
// collector state encoding.
package he_xpose_pkg;

    // Chunk width as seen on every lane of a switch stage; the collector
    // uses the same formula so its lanes line up with the last stage.
    function automatic int unsigned chunk_width(
        input int unsigned num_mg,
        input int unsigned num_pe,
        input int unsigned data_width
    );
        return num_mg / num_pe * data_width;
    endfunction

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } collector_state_t;

endpackage

// File: rtl/tile_read_mux.sv
// Combinational row/column select over a stored tile: returns row rd_cnt,
// or column rd_cnt when mode_t is set.
module tile_read_mux #(
    parameter int unsigned CHUNK_WIDTH = 64,
    parameter int unsigned NUM_PE      = 8,
    parameter int unsigned IDX_W       = $clog2(NUM_PE)
) (
    input  logic [0:NUM_PE-1][0:NUM_PE-1][CHUNK_WIDTH-1:0] tile,
    input  logic [IDX_W-1:0]                               rd_cnt,
    input  logic                                           mode_t,
    output logic [0:NUM_PE-1][CHUNK_WIDTH-1:0]             out_elements
);

    for (genvar c = 0; c < NUM_PE; c++) begin : g_lane
        assign out_elements[c] = mode_t ? tile[c][rd_cnt] : tile[rd_cnt][c];
    end

endmodule

// File: rtl/tile_transpose_collector.sv
// Single-buffered tile collector: fills a NUM_PE x NUM_PE tile one row per beat,
// then drains it row by row, optionally transposed.
module tile_transpose_collector
    import he_xpose_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH  = 64,
    parameter  int unsigned NUM_PE      = 8,
    parameter  int unsigned NUM_MG      = NUM_PE,
    localparam int unsigned CHUNK_WIDTH = chunk_width(NUM_MG, NUM_PE, DATA_WIDTH),
    localparam int unsigned IDX_W       = $clog2(NUM_PE)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [0:NUM_PE-1][CHUNK_WIDTH-1:0]  in_elements,
    input  logic                                in_transpose,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [0:NUM_PE-1][CHUNK_WIDTH-1:0]  out_elements,
    output logic [IDX_W-1:0]                    out_row_idx,
    output logic                                out_last
);

    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(NUM_PE - 1);

    collector_state_t                              state_q, state_d;
    logic [0:NUM_PE-1][0:NUM_PE-1][CHUNK_WIDTH-1:0] tile_q, tile_d;
    logic [IDX_W-1:0]                              wr_cnt_q, wr_cnt_d;
    logic [IDX_W-1:0]                              rd_cnt_q, rd_cnt_d;
    logic                                          mode_t_q, mode_t_d;

    always_comb begin
        state_d  = state_q;
        tile_d   = tile_q;
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        mode_t_d = mode_t_q;
        unique case (state_q)
            FILL: begin
                if (in_valid) begin
                    tile_d[wr_cnt_q] = in_elements;
                    wr_cnt_d         = wr_cnt_q + IDX_W'(1);
                    // Tile mode is latched from row 0 only.
                    if (wr_cnt_q == '0) begin
                        mode_t_d = in_transpose;
                    end
                    if (wr_cnt_q == LAST_ROW) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    rd_cnt_d = rd_cnt_q + IDX_W'(1);
                    if (rd_cnt_q == LAST_ROW) begin
                        state_d = FILL;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FILL;
            tile_q   <= '0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            mode_t_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tile_q   <= tile_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            mode_t_q <= mode_t_d;
        end
    end

    assign in_ready    = (state_q == FILL);
    assign out_valid   = (state_q == DRAIN);
    assign out_row_idx = rd_cnt_q;
    assign out_last    = (state_q == DRAIN) && (rd_cnt_q == LAST_ROW);

    tile_read_mux #(
        .CHUNK_WIDTH (CHUNK_WIDTH),
        .NUM_PE      (NUM_PE),
        .IDX_W       (IDX_W)
    ) u_read_mux (
        .tile         (tile_q),
        .rd_cnt       (rd_cnt_q),
        .mode_t       (mode_t_q),
        .out_elements (out_elements)
    );

endmodule
